// File: rtl/ysyx_22041211_wb_unit_pkg.sv
// Shared definitions for the write-back stage: state encodings, GPR sizing, CSR address width.
package ysyx_22041211_wb_unit_pkg;

  // 2'b11 is unused; the FSM steers it back to WB_IDLE.
  typedef enum logic [1:0] {
    WB_IDLE  = 2'b00,
    WB_WRITE = 2'b01,
    WB_DONE  = 2'b10
  } wb_state_e;

  localparam int unsigned CSR_ADDR_LEN     = 12;
  localparam int unsigned GPR_ADDR_LEN_DEF = 5;
  localparam int unsigned GPR_NUM          = 2 ** GPR_ADDR_LEN_DEF;
  localparam int unsigned REG_ZERO         = 0;

  // Number of GPR entries for a given index width.
  function automatic int unsigned gpr_count(input int unsigned addr_len);
    return 32'd1 << addr_len;
  endfunction

endpackage

// File: rtl/ysyx_22041211_gpr_file.sv
// General-purpose register file: two combinational read ports, one synchronous write port,
// synchronous reset-to-zero, x0 hardwired to zero.
module ysyx_22041211_gpr_file
  import ysyx_22041211_wb_unit_pkg::*;
#(
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned REG_ADDR_LEN = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [REG_ADDR_LEN-1:0] i_waddr,
  input  logic [DATA_LEN-1:0]     i_wdata,
  input  logic [REG_ADDR_LEN-1:0] i_raddr1,
  input  logic [REG_ADDR_LEN-1:0] i_raddr2,
  output logic [DATA_LEN-1:0]     o_rdata1,
  output logic [DATA_LEN-1:0]     o_rdata2
);

  localparam int unsigned NumRegs = gpr_count(REG_ADDR_LEN);

  logic [DATA_LEN-1:0]     r_gpr [NumRegs];
  logic [REG_ADDR_LEN-1:0] w_zero_idx;

  assign w_zero_idx = REG_ADDR_LEN'(REG_ZERO);

  // Reset clears every entry; writes to x0 are dropped so it never holds non-zero data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        r_gpr[REG_ADDR_LEN'(i)] <= '0;
      end
    end else if (i_we && (i_waddr != w_zero_idx)) begin
      r_gpr[i_waddr] <= i_wdata;
    end
  end

  // Combinational reads with no write bypass; x0 forced to zero.
  always_comb begin
    o_rdata1 = (i_raddr1 == w_zero_idx) ? '0 : r_gpr[i_raddr1];
    o_rdata2 = (i_raddr2 == w_zero_idx) ? '0 : r_gpr[i_raddr2];
  end

endmodule

// File: rtl/ysyx_22041211_wb_unit.sv
// Write-back stage: buffers one retired instruction, commits it to the GPR file and CSR file,
// then pulses wb_valid_o to release the fetch stage. Three cycles per instruction.
module ysyx_22041211_wb_unit
  import ysyx_22041211_wb_unit_pkg::*;
#(
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned REG_ADDR_LEN = 5,
  parameter int unsigned CNT_LEN      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lsu_valid_i,
  output logic                    wb_ready_o,
  input  logic                    wd_i,
  input  logic [REG_ADDR_LEN-1:0] wreg_i,
  input  logic [DATA_LEN-1:0]     wdata_i,
  input  logic                    csr_we_i,
  input  logic [CSR_ADDR_LEN-1:0] csr_addr_i,
  input  logic [DATA_LEN-1:0]     csr_wdata_i,
  input  logic [REG_ADDR_LEN-1:0] rs1_addr_i,
  input  logic [REG_ADDR_LEN-1:0] rs2_addr_i,
  output logic [DATA_LEN-1:0]     rs1_data_o,
  output logic [DATA_LEN-1:0]     rs2_data_o,
  output logic                    csr_we_o,
  output logic [CSR_ADDR_LEN-1:0] csr_addr_o,
  output logic [DATA_LEN-1:0]     csr_wdata_o,
  output logic                    wb_valid_o,
  output logic [CNT_LEN-1:0]      retire_cnt_o
);

  wb_state_e r_state;
  wb_state_e w_state_next;

  // Instruction buffer, loaded at the accept edge.
  logic                    r_wd;
  logic [REG_ADDR_LEN-1:0] r_wreg;
  logic [DATA_LEN-1:0]     r_wdata;
  logic                    r_csr_we;
  logic [CSR_ADDR_LEN-1:0] r_csr_addr;
  logic [DATA_LEN-1:0]     r_csr_wdata;

  logic [CNT_LEN-1:0] r_retire_cnt;

  logic w_accept;
  logic w_ready;
  logic w_gpr_we;
  logic w_csr_we;
  logic w_wb_valid;

  // Next state and per-state strobes; rst masks any commit or retire in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_gpr_we     = 1'b0;
    w_csr_we     = 1'b0;
    w_wb_valid   = 1'b0;
    case (r_state)
      WB_IDLE: begin
        w_ready = 1'b1;
        if (lsu_valid_i) w_state_next = WB_WRITE;
      end
      WB_WRITE: begin
        w_gpr_we     = r_wd && (r_wreg != REG_ADDR_LEN'(REG_ZERO)) && !rst;
        w_csr_we     = r_csr_we && !rst;
        w_state_next = WB_DONE;
      end
      WB_DONE: begin
        w_wb_valid   = !rst;
        w_state_next = WB_IDLE;
      end
      default: begin
        w_state_next = WB_IDLE;
      end
    endcase
  end

  assign w_accept = (r_state == WB_IDLE) && lsu_valid_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the incoming instruction on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd        <= 1'b0;
      r_wreg      <= '0;
      r_wdata     <= '0;
      r_csr_we    <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
    end else if (w_accept) begin
      r_wd        <= wd_i;
      r_wreg      <= wreg_i;
      r_wdata     <= wdata_i;
      r_csr_we    <= csr_we_i;
      r_csr_addr  <= csr_addr_i;
      r_csr_wdata <= csr_wdata_i;
    end
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (r_state == WB_DONE) begin
      r_retire_cnt <= r_retire_cnt + CNT_LEN'(1);
    end
  end

  ysyx_22041211_gpr_file #(
    .DATA_LEN    (DATA_LEN),
    .REG_ADDR_LEN(REG_ADDR_LEN)
  ) u_gpr_file (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_gpr_we),
    .i_waddr (r_wreg),
    .i_wdata (r_wdata),
    .i_raddr1(rs1_addr_i),
    .i_raddr2(rs2_addr_i),
    .o_rdata1(rs1_data_o),
    .o_rdata2(rs2_data_o)
  );

  assign wb_ready_o   = w_ready;
  assign wb_valid_o   = w_wb_valid;
  assign csr_we_o     = w_csr_we;
  assign csr_addr_o   = r_csr_addr;
  assign csr_wdata_o  = r_csr_wdata;
  assign retire_cnt_o = r_retire_cnt;

endmodule

// File: tb/tb_ysyx_22041211_wb_unit.sv
// Directed bench for the write-back stage with a scoreboard of accepted instructions.
module tb_ysyx_22041211_wb_unit;

  typedef struct packed {
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        csr_we;
    logic [11:0] caddr;
    logic [31:0] cdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_i;
  logic        wb_ready_o;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] wdata_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        csr_we_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic        wb_valid_o;
  logic [63:0] retire_cnt_o;

  // Narrow-counter instance sharing all inputs, used to observe wrap-around.
  logic        n_ready;
  logic [31:0] n_rs1;
  logic [31:0] n_rs2;
  logic        n_csr_we;
  logic [11:0] n_csr_addr;
  logic [31:0] n_csr_wdata;
  logic        n_valid;
  logic [1:0]  n_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_gpr [32];
  logic [63:0] exp_cnt;
  exp_t        sb [$];

  always #5 clk = ~clk;

  ysyx_22041211_wb_unit dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid_i (lsu_valid_i),
    .wb_ready_o  (wb_ready_o),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .csr_we_i    (csr_we_i),
    .csr_addr_i  (csr_addr_i),
    .csr_wdata_i (csr_wdata_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs1_data_o  (rs1_data_o),
    .rs2_data_o  (rs2_data_o),
    .csr_we_o    (csr_we_o),
    .csr_addr_o  (csr_addr_o),
    .csr_wdata_o (csr_wdata_o),
    .wb_valid_o  (wb_valid_o),
    .retire_cnt_o(retire_cnt_o)
  );

  ysyx_22041211_wb_unit #(
    .CNT_LEN(2)
  ) dut_narrow (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid_i (lsu_valid_i),
    .wb_ready_o  (n_ready),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .csr_we_i    (csr_we_i),
    .csr_addr_i  (csr_addr_i),
    .csr_wdata_i (csr_wdata_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs1_data_o  (n_rs1),
    .rs2_data_o  (n_rs2),
    .csr_we_o    (n_csr_we),
    .csr_addr_o  (n_csr_addr),
    .csr_wdata_o (n_csr_wdata),
    .wb_valid_o  (n_valid),
    .retire_cnt_o(n_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction from an idle cycle (called at a negedge) through to the next idle cycle.
  task automatic run_txn(input exp_t t);
    exp_t e;
    wd_i        = t.wd;
    wreg_i      = t.wreg;
    wdata_i     = t.wdata;
    csr_we_i    = t.csr_we;
    csr_addr_i  = t.caddr;
    csr_wdata_i = t.cdata;
    lsu_valid_i = 1'b1;
    #1;
    check("ready_before_accept", {63'd0, wb_ready_o}, 64'd1);
    @(posedge clk);
    sb.push_back(t);
    #1;
    // Scramble inputs so the outputs must come from the buffer.
    lsu_valid_i = 1'b0;
    wdata_i     = ~t.wdata;
    csr_wdata_i = ~t.cdata;
    csr_addr_i  = ~t.caddr;
    wreg_i      = ~t.wreg;
    @(negedge clk);
    e          = sb.pop_front();
    rs1_addr_i = e.wreg;
    rs2_addr_i = 5'd0;
    #1;
    check("write_ready", {63'd0, wb_ready_o}, 64'd0);
    check("write_valid", {63'd0, wb_valid_o}, 64'd0);
    check("write_csr_we", {63'd0, csr_we_o}, {63'd0, e.csr_we});
    if (e.csr_we) begin
      check("write_csr_addr", {52'd0, csr_addr_o}, {52'd0, e.caddr});
      check("write_csr_data", {32'd0, csr_wdata_o}, {32'd0, e.cdata});
    end
    check("write_rs1_old", {32'd0, rs1_data_o}, {32'd0, m_gpr[e.wreg]});
    check("write_rs2_x0", {32'd0, rs2_data_o}, 64'd0);
    @(posedge clk);
    if (e.wd && e.wreg != 5'd0) m_gpr[e.wreg] = e.wdata;
    @(negedge clk);
    #1;
    check("done_ready", {63'd0, wb_ready_o}, 64'd0);
    check("done_valid", {63'd0, wb_valid_o}, 64'd1);
    check("done_csr_we", {63'd0, csr_we_o}, 64'd0);
    check("done_rs1_new", {32'd0, rs1_data_o}, {32'd0, m_gpr[e.wreg]});
    @(posedge clk);
    exp_cnt = exp_cnt + 64'd1;
    @(negedge clk);
    #1;
    check("idle_ready", {63'd0, wb_ready_o}, 64'd1);
    check("idle_valid", {63'd0, wb_valid_o}, 64'd0);
    check("retire_cnt", retire_cnt_o, exp_cnt);
    check("retire_cnt_narrow", {62'd0, n_cnt}, {62'd0, exp_cnt[1:0]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t t;
    int   pulses;
    rst         = 1'b1;
    lsu_valid_i = 1'b0;
    wd_i        = 1'b0;
    wreg_i      = '0;
    wdata_i     = '0;
    csr_we_i    = 1'b0;
    csr_addr_i  = '0;
    csr_wdata_i = '0;
    rs1_addr_i  = 5'd5;
    rs2_addr_i  = 5'd31;
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", {63'd0, wb_ready_o}, 64'd1);
    check("rst_valid", {63'd0, wb_valid_o}, 64'd0);
    check("rst_csr_we", {63'd0, csr_we_o}, 64'd0);
    check("rst_cnt", retire_cnt_o, 64'd0);
    check("rst_rs1", {32'd0, rs1_data_o}, 64'd0);
    check("rst_rs2", {32'd0, rs2_data_o}, 64'd0);
    @(negedge clk);

    // GPR write to x5.
    t = '{wd: 1'b1, wreg: 5'd5, wdata: 32'hDEAD_BEEF, csr_we: 1'b0, caddr: 12'h000, cdata: 32'h0};
    run_txn(t);
    // Write to x0 is dropped but still retires.
    t = '{wd: 1'b1, wreg: 5'd0, wdata: 32'h0000_1234, csr_we: 1'b0, caddr: 12'h000, cdata: 32'h0};
    run_txn(t);
    // CSR write only; x5 must keep its value.
    t = '{wd: 1'b0, wreg: 5'd5, wdata: 32'h1111_2222, csr_we: 1'b1, caddr: 12'h305,
          cdata: 32'h8000_0000};
    run_txn(t);
    // Fourth retire: narrow counter goes 3 -> 0.
    t = '{wd: 1'b1, wreg: 5'd31, wdata: 32'hCAFE_F00D, csr_we: 1'b1, caddr: 12'h341,
          cdata: 32'h0000_0042};
    run_txn(t);
    check("wrap_narrow_zero", {62'd0, n_cnt}, 64'd0);

    // Back-to-back: valid held for 6 cycles, data changes every cycle.
    pulses      = 0;
    lsu_valid_i = 1'b1;
    wd_i        = 1'b1;
    csr_we_i    = 1'b0;
    for (int c = 0; c < 6; c++) begin
      wreg_i  = 5'd10 + 5'(c);
      wdata_i = 32'hA000_0000 + 32'(c);
      #1;
      check("b2b_ready", {63'd0, wb_ready_o}, {63'd0, (c % 3) == 0});
      check("b2b_valid", {63'd0, wb_valid_o}, {63'd0, (c % 3) == 2});
      if (wb_valid_o) pulses++;
      if ((c % 3) == 0) m_gpr[10 + c] = 32'hA000_0000 + 32'(c);
      @(negedge clk);
    end
    lsu_valid_i = 1'b0;
    exp_cnt     = exp_cnt + 64'd2;
    rs1_addr_i  = 5'd10;
    rs2_addr_i  = 5'd13;
    #1;
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_gpr10", {32'd0, rs1_data_o}, {32'd0, m_gpr[10]});
    check("b2b_gpr13", {32'd0, rs2_data_o}, {32'd0, m_gpr[13]});
    rs1_addr_i = 5'd11;
    rs2_addr_i = 5'd12;
    #1;
    check("b2b_gpr11", {32'd0, rs1_data_o}, 64'd0);
    check("b2b_gpr12", {32'd0, rs2_data_o}, 64'd0);
    check("b2b_cnt", retire_cnt_o, exp_cnt);
    check("b2b_cnt_narrow", {62'd0, n_cnt}, {62'd0, exp_cnt[1:0]});
    @(negedge clk);

    // Reset while in WB_WRITE with a pending write to x7 and a CSR write.
    wd_i        = 1'b1;
    wreg_i      = 5'd7;
    wdata_i     = 32'h7777_7777;
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h300;
    csr_wdata_i = 32'h0000_0008;
    lsu_valid_i = 1'b1;
    @(posedge clk);
    #1;
    lsu_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_csr_we", {63'd0, csr_we_o}, 64'd0);
    check("rst_mid_valid", {63'd0, wb_valid_o}, 64'd0);
    @(posedge clk);
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    exp_cnt = '0;
    sb.delete();
    @(negedge clk);
    rst        = 1'b0;
    rs1_addr_i = 5'd7;
    rs2_addr_i = 5'd5;
    #1;
    check("rst_mid_ready", {63'd0, wb_ready_o}, 64'd1);
    check("rst_mid_valid_after", {63'd0, wb_valid_o}, 64'd0);
    check("rst_mid_csr_after", {63'd0, csr_we_o}, 64'd0);
    check("rst_mid_gpr7", {32'd0, rs1_data_o}, 64'd0);
    check("rst_mid_gpr5", {32'd0, rs2_data_o}, 64'd0);
    check("rst_mid_cnt", retire_cnt_o, 64'd0);
    @(negedge clk);
    #1;
    check("rst_mid_valid_late", {63'd0, wb_valid_o}, 64'd0);
    check("rst_mid_cnt_late", retire_cnt_o, 64'd0);
    @(negedge clk);

    // Normal operation resumes after reset.
    t = '{wd: 1'b1, wreg: 5'd7, wdata: 32'h0BAD_CAFE, csr_we: 1'b0, caddr: 12'h000, cdata: 32'h0};
    run_txn(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
